// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader and its program buffer.
package loader_pkg;
  localparam int unsigned DEPTH_DEFAULT     = 32;
  localparam int unsigned ISA_WIDTH_DEFAULT = 16;
  localparam int unsigned BYTES_PER_INST    = 2;
  localparam int unsigned BYTE_W            = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HOLD,
    BURN,
    REARM,
    DONE
  } state_e;
endpackage

// File: rtl/inst_buf.sv
// Program buffer: register array with one synchronous write port and one combinational read port.
module inst_buf
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = ISA_WIDTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];
endmodule

// File: rtl/inst_loader.sv
// Program burner: collects a byte stream into 16-bit words, then replays them into icmem
// with the core's PC held in reset just before the first write.
module inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned ISA_WIDTH = ISA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned LEN_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     prog_len,
  input  logic                 byte_valid,
  input  logic [BYTE_W-1:0]    byte_data,
  output logic                 byte_ready,
  output logic                 core_rst,
  output logic                 inst_wen,
  output logic [ISA_WIDTH-1:0] input_inst,
  output logic                 busy,
  output logic                 done
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PACK_W = BYTES_PER_INST * BYTE_W;

  state_e               state, state_d;
  logic [LEN_W-1:0]     len, wcnt, rcnt;
  logic                 phase;
  logic [BYTE_W-1:0]    hi_byte;
  logic                 start_ok, xfer, buf_wen;
  logic [PACK_W-1:0]    word_c;
  logic [ISA_WIDTH-1:0] rd_data;
  logic                 byte_ready_d, core_rst_d, inst_wen_d, busy_d, done_d;
  logic [ISA_WIDTH-1:0] input_inst_d;

  assign start_ok = start && (prog_len != '0);
  assign xfer     = byte_valid && byte_ready;
  assign word_c   = {hi_byte, byte_data};

  inst_buf #(
    .DEPTH (DEPTH),
    .WIDTH (ISA_WIDTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wen     (buf_wen),
    .waddr   (wcnt[AW-1:0]),
    .wdata   (ISA_WIDTH'(word_c)),
    .raddr   (rcnt[AW-1:0]),
    .rdata_c (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state plus output decode; outputs are taken from the next state so they register in step with it.
  always_comb begin
    state_d      = state;
    buf_wen      = 1'b0;
    byte_ready_d = 1'b0;
    core_rst_d   = 1'b0;
    inst_wen_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    input_inst_d = '0;
    case (state)
      IDLE, DONE: if (start_ok) state_d = COLLECT;
      COLLECT: begin
        if (xfer && phase) begin
          buf_wen = 1'b1;
          if (wcnt == len - LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD:    state_d = BURN;
      BURN:    if (rcnt == len) state_d = REARM;
      REARM:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    byte_ready_d = (state_d == COLLECT);
    core_rst_d   = (state_d == BURN) || (state_d == DONE);
    inst_wen_d   = (state_d == BURN);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
    if (inst_wen_d) input_inst_d = rd_data;
  end

  // rcnt is the index of the next word to present; it advances on every edge that lands in BURN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_ready <= 1'b0;
      core_rst   <= 1'b0;
      inst_wen   <= 1'b0;
      input_inst <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      len        <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
    end else begin
      byte_ready <= byte_ready_d;
      core_rst   <= core_rst_d;
      inst_wen   <= inst_wen_d;
      input_inst <= input_inst_d;
      busy       <= busy_d;
      done       <= done_d;
      if ((state == IDLE || state == DONE) && start_ok) begin
        len   <= (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
        wcnt  <= '0;
        rcnt  <= '0;
        phase <= 1'b0;
      end
      if (state == COLLECT && xfer) begin
        phase <= ~phase;
        if (phase) wcnt <= wcnt + LEN_W'(1);
        else       hi_byte <= byte_data;
      end
      if (state_d == BURN) rcnt <= rcnt + LEN_W'(1);
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a behavioural icmem model on the write port.
`timescale 1ns/1ps
module tb_inst_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  prog_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, core_rst, inst_wen, busy, done;
  logic [15:0] input_inst;

  int total = 0;
  int bad   = 0;
  logic [7:0]  src [80];
  logic [15:0] snap [5];

  always #5 clk = ~clk;

  inst_loader #(.ISA_WIDTH(16), .DEPTH(32), .LEN_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_len   (prog_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .core_rst   (core_rst),
    .inst_wen   (inst_wen),
    .input_inst (input_inst),
    .busy       (busy),
    .done       (done)
  );

  // icmem model plus transfer/write counters
  logic [15:0] imem [32];
  logic [5:0]  pc;
  int          xfer_cnt = 0, wen_cnt = 0, nz_cnt = 0;
  logic        mon_clr = 1'b0;

  always @(posedge clk) begin
    if (mon_clr) begin
      xfer_cnt <= 0;
      wen_cnt  <= 0;
      nz_cnt   <= 0;
      for (int i = 0; i < 32; i++) imem[i] <= 16'hDEAD;
    end else begin
      if (byte_valid && byte_ready) xfer_cnt <= xfer_cnt + 1;
      if (inst_wen) wen_cnt <= wen_cnt + 1;
      if (!inst_wen && input_inst != 16'h0) nz_cnt <= nz_cnt + 1;
      if (core_rst && inst_wen) imem[pc[4:0]] <= input_inst;
    end
    if (!core_rst) pc <= '0;
    else           pc <= pc + 6'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] plen);
    start    = 1'b1;
    prog_len = plen;
    step();
    start    = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int budget = 0;
    while (xfer_cnt < n && budget < 500) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = src[xfer_cnt];
      step();
      budget++;
    end
    byte_valid = 1'b0;
    total++;
    if (xfer_cnt != n) begin bad++; $display("FAIL feed: accepted=%0d required=%0d", xfer_cnt, n); end
  endtask

  task automatic wait_done(input bit keep_offer);
    int budget = 0;
    byte_valid = keep_offer;
    byte_data  = 8'hEE;
    while (done !== 1'b1 && budget < 200) begin
      step();
      budget++;
    end
    byte_valid = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL wait_done: done=%b required=1 after %0d cycles", done, budget); end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready: got=%b want=0", byte_ready); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL reset_core_rst: got=%b want=0", core_rst); end
    total++; if (inst_wen !== 1'b0) begin bad++; $display("FAIL reset_inst_wen: got=%b want=0", inst_wen); end
    total++; if (input_inst !== 16'h0) begin bad++; $display("FAIL reset_input_inst: got=%h want=0000", input_inst); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b want=0", done); end
    rst = 1'b1;
    clear_mon();
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL idle_core_rst: got=%b want=0", core_rst); end
  endtask

  task automatic test_zero_len();
    pulse_start(6'd0);
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_len_busy: got=%b want=0", busy); end
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL zero_len_ready: got=%b want=0", byte_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_len_done: got=%b want=0", done); end
  endtask

  task automatic test_load3();
    logic [15:0] exp3 [3];
    exp3[0] = 16'h1234; exp3[1] = 16'hABCD; exp3[2] = 16'h00FF;
    src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'hAB;
    src[3] = 8'hCD; src[4] = 8'h00; src[5] = 8'hFF;
    clear_mon();
    pulse_start(6'd3);
    total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL load3_ready_up: got=%b want=1", byte_ready); end
    feed(6, 1'b0);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL load3_ready_drop: got=%b want=0", byte_ready); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL load3_hold_core_rst: got=%b want=0", core_rst); end
    total++; if (inst_wen !== 1'b0) begin bad++; $display("FAIL load3_hold_wen: got=%b want=0", inst_wen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL load3_hold_busy: got=%b want=1", busy); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (inst_wen !== 1'b1) begin bad++; $display("FAIL load3_burn_wen[%0d]: got=%b want=1", k, inst_wen); end
      total++; if (input_inst !== exp3[k]) begin bad++; $display("FAIL load3_burn_inst[%0d]: got=%h want=%h", k, input_inst, exp3[k]); end
      total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL load3_burn_core_rst[%0d]: got=%b want=1", k, core_rst); end
    end
    step();
    total++; if (inst_wen !== 1'b0) begin bad++; $display("FAIL load3_rearm_wen: got=%b want=0", inst_wen); end
    total++; if (input_inst !== 16'h0) begin bad++; $display("FAIL load3_rearm_inst: got=%h want=0000", input_inst); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL load3_rearm_core_rst: got=%b want=0", core_rst); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL load3_done: got=%b want=1", done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL load3_done_core_rst: got=%b want=1", core_rst); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load3_done_busy: got=%b want=0", busy); end
    for (int k = 0; k < 3; k++) begin
      total++; if (imem[k] !== exp3[k]) begin bad++; $display("FAIL load3_mem[%0d]: got=%h want=%h", k, imem[k], exp3[k]); end
    end
    total++; if (wen_cnt != 3) begin bad++; $display("FAIL load3_wen_count: got=%0d want=3", wen_cnt); end
    total++; if (nz_cnt != 0) begin bad++; $display("FAIL load3_idle_inst_nonzero: got=%0d want=0", nz_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp5 [5];
    exp5[0] = 16'h1122; exp5[1] = 16'h3344; exp5[2] = 16'h5566;
    exp5[3] = 16'h7788; exp5[4] = 16'h99AA;
    for (int i = 0; i < 10; i++) src[i] = 8'((i + 1) * 8'h11);
    clear_mon();
    pulse_start(6'd5);
    feed(10, 1'b0);
    wait_done(1'b0);
    for (int k = 0; k < 5; k++) snap[k] = imem[k];
    clear_mon();
    pulse_start(6'd5);
    feed(10, 1'b1);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_10: got=%b want=0", byte_ready); end
    wait_done(1'b0);
    for (int k = 0; k < 5; k++) begin
      total++; if (imem[k] !== exp5[k]) begin bad++; $display("FAIL bp_mem[%0d]: got=%h want=%h", k, imem[k], exp5[k]); end
      total++; if (snap[k] !== exp5[k]) begin bad++; $display("FAIL b2b_mem[%0d]: got=%h want=%h", k, snap[k], exp5[k]); end
    end
    total++; if (xfer_cnt != 10) begin bad++; $display("FAIL bp_bytes: got=%0d want=10", xfer_cnt); end
    total++; if (wen_cnt != 5) begin bad++; $display("FAIL bp_writes: got=%0d want=5", wen_cnt); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 64; i++) src[i] = 8'(i);
    clear_mon();
    pulse_start(6'd40);
    feed(64, 1'b0);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL clamp_ready_after_64: got=%b want=0", byte_ready); end
    wait_done(1'b1);
    total++; if (xfer_cnt != 64) begin bad++; $display("FAIL clamp_bytes: got=%0d want=64", xfer_cnt); end
    total++; if (wen_cnt != 32) begin bad++; $display("FAIL clamp_writes: got=%0d want=32", wen_cnt); end
    total++; if (imem[0] !== 16'h0001) begin bad++; $display("FAIL clamp_mem0: got=%h want=0001", imem[0]); end
    total++; if (imem[16] !== 16'h2021) begin bad++; $display("FAIL clamp_mem16: got=%h want=2021", imem[16]); end
    total++; if (imem[31] !== 16'h3E3F) begin bad++; $display("FAIL clamp_mem31: got=%h want=3E3F", imem[31]); end
  endtask

  task automatic test_mid_reset();
    src[0] = 8'hC1; src[1] = 8'hC2; src[2] = 8'hC3;
    clear_mon();
    pulse_start(6'd4);
    feed(3, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got=%b want=0", byte_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got=%b want=0", busy); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL midrst_core_rst: got=%b want=0", core_rst); end
    src[0] = 8'h5A; src[1] = 8'hA5; src[2] = 8'h3C; src[3] = 8'hC3;
    clear_mon();
    pulse_start(6'd2);
    feed(4, 1'b0);
    wait_done(1'b0);
    total++; if (imem[0] !== 16'h5AA5) begin bad++; $display("FAIL midrst_mem0: got=%h want=5AA5", imem[0]); end
    total++; if (imem[1] !== 16'h3CC3) begin bad++; $display("FAIL midrst_mem1: got=%h want=3CC3", imem[1]); end
    total++; if (wen_cnt != 2) begin bad++; $display("FAIL midrst_writes: got=%0d want=2", wen_cnt); end
  endtask

  task automatic test_ignored_starts();
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    clear_mon();
    pulse_start(6'd4);
    feed(8, 1'b0);
    step();
    pulse_start(6'd1);
    total++; if (inst_wen !== 1'b1) begin bad++; $display("FAIL ign_burn_wen: got=%b want=1", inst_wen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_burn_busy: got=%b want=1", busy); end
    wait_done(1'b0);
    total++; if (wen_cnt != 4) begin bad++; $display("FAIL ign_writes: got=%0d want=4", wen_cnt); end
    total++; if (imem[0] !== 16'h0102) begin bad++; $display("FAIL ign_mem0: got=%h want=0102", imem[0]); end
    total++; if (imem[3] !== 16'h0708) begin bad++; $display("FAIL ign_mem3: got=%h want=0708", imem[3]); end
    total++; if (xfer_cnt != 8) begin bad++; $display("FAIL ign_bytes: got=%0d want=8", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_load3();
    test_backpressure();
    test_clamp();
    test_mid_reset();
    test_ignored_starts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
